// File: rtl/uart_frame_parser_if.sv
// Bundle between the UART receiver, the frame parser and the command consumer.
// master: parser side (drives frame/error outputs); slave: receiver/consumer side.
interface uart_frame_parser_if;
   logic       uart_done;
   logic [7:0] uart_data;
   logic       frm_ack;
   logic       frm_valid;
   logic [7:0] frm_cmd;
   logic [7:0] frm_len;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       frm_err;
   logic [1:0] err_code;

   modport master (
      input  uart_done, uart_data, frm_ack, rd_addr,
      output frm_valid, frm_cmd, frm_len, rd_data, frm_err, err_code
   );

   modport slave (
      output uart_done, uart_data, frm_ack, rd_addr,
      input  frm_valid, frm_cmd, frm_len, rd_data, frm_err, err_code
   );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles 55 AA CMD LEN payload CSUM frames from UART receiver bytes.
// Ports: sys_clk, sys_rst (async, high); bus = uart_done/uart_data in,
// frm_ack/rd_addr in, frm_valid/frm_cmd/frm_len/rd_data/frm_err/err_code out.
module uart_frame_parser #(
   parameter int          MAX_LEN     = 16,
   parameter logic [23:0] TIMEOUT_CNT = 24'd50000
) (
   input logic                 sys_clk,
   input logic                 sys_rst,
   uart_frame_parser_if.master bus
);
   localparam int         AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAXL = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE, HDR2, CMD, LEN, DATA, CSUM, HOLD
   } state_t;

   state_t      state_q, state_d;
   logic        done_q;
   logic        byte_stb;
   logic [7:0]  b;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  fcmd_q, fcmd_d;
   logic [7:0]  flen_q, flen_d;
   logic [23:0] tcnt_q, tcnt_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic        we;
   logic        active;
   logic        tout;
   logic [7:0]  buf_q [MAX_LEN];

   assign b        = bus.uart_data;
   // One strobe per byte regardless of how long uart_done stays high.
   assign byte_stb = bus.uart_done & ~done_q;
   assign active   = (state_q != IDLE) && (state_q != HOLD);
   assign tout     = (tcnt_q == TIMEOUT_CNT - 24'd1);

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      fcmd_d  = fcmd_q;
      flen_d  = flen_q;
      err_d   = 1'b0;
      code_d  = code_q;
      we      = 1'b0;
      tcnt_d  = (active && !byte_stb) ? tcnt_q + 24'd1 : '0;
      unique case (state_q)
         IDLE: if (byte_stb && b == 8'h55) state_d = HDR2;
         HDR2: if (byte_stb) begin
            if (b == 8'hAA)      state_d = CMD;
            else if (b != 8'h55) state_d = IDLE;
         end
         CMD: if (byte_stb) begin
            cmd_d   = b;
            sum_d   = b;
            state_d = LEN;
         end
         LEN: if (byte_stb) begin
            len_d = b;
            sum_d = sum_q + b;
            idx_d = '0;
            if (b > MAXL) begin
               state_d = IDLE;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else if (b == 8'd0) begin
               state_d = CSUM;
            end else begin
               state_d = DATA;
            end
         end
         DATA: if (byte_stb) begin
            we    = 1'b1;
            sum_d = sum_q + b;
            idx_d = idx_q + 8'd1;
            if (idx_q + 8'd1 == len_q) state_d = CSUM;
         end
         CSUM: if (byte_stb) begin
            if (b == sum_q) begin
               state_d = HOLD;
               fcmd_d  = cmd_q;
               flen_d  = len_q;
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
               code_d  = 2'd1;
            end
         end
         HOLD: begin
            // Ack wins over a coincident byte, which is then
            // treated as the first byte seen in IDLE.
            if (bus.frm_ack) begin
               state_d = (byte_stb && b == 8'h55) ? HDR2 : IDLE;
            end else if (byte_stb) begin
               err_d  = 1'b1;
               code_d = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (active && !byte_stb && tout) begin
         state_d = IDLE;
         tcnt_d  = '0;
         err_d   = 1'b1;
         code_d  = 2'd3;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         cmd_q   <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         fcmd_q  <= '0;
         flen_q  <= '0;
         tcnt_q  <= '0;
         err_q   <= 1'b0;
         code_q  <= '0;
         for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= bus.uart_done;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         fcmd_q  <= fcmd_d;
         flen_q  <= flen_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
         code_q  <= code_d;
         if (we) buf_q[idx_q[AW-1:0]] <= b;
      end
   end

   assign bus.frm_valid = (state_q == HOLD);
   assign bus.frm_cmd   = fcmd_q;
   assign bus.frm_len   = flen_q;
   assign bus.frm_err   = err_q;
   assign bus.err_code  = code_q;
   assign bus.rd_data   = (bus.rd_addr < MAXL) ?
                          buf_q[bus.rd_addr[AW-1:0]] : 8'h00;
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver: consumes its per-byte done/data outputs and assembles framed command packets.
- Frame format: 0x55, 0xAA, CMD, LEN, LEN payload bytes, CSUM.
- Validates header, length, checksum and inter-byte timeout.
- Holds a completed frame (cmd, len, payload buffer) for the command consumer until acknowledged.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal LEN range is 0..MAX_LEN.
TIMEOUT_CNT, 24'd50000, idle sys_clk cycles allowed between bytes inside a frame before abort.

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous reset, active-high
uart_done  input  1  receiver byte-complete flag; may stay high for many cycles per byte
uart_data  input  8  received byte; valid while uart_done is high
frm_ack  input  1  consumer acknowledges the held frame
frm_valid  output  1  complete, checksum-correct frame held
frm_cmd  output  8  CMD byte of the held frame
frm_len  output  8  LEN byte of the held frame
rd_addr  input  8  payload buffer read index
rd_data  output  8  payload[rd_addr], combinational; 0 when rd_addr >= MAX_LEN
frm_err  output  1  one-cycle error pulse
err_code  output  2  0 overrun, 1 checksum, 2 length, 3 timeout; holds the last error

Behaviour:
- Reset (async, sys_rst=1):
  - state IDLE; done_d, byte counters, checksum and timeout counter cleared.
  - frm_valid, frm_err, err_code, frm_cmd, frm_len all 0; payload buffer cleared to 0.
- Byte strobe:
  - done_d registers uart_done.
  - byte_stb = uart_done & ~done_d. Exactly one strobe per byte, however long uart_done is held.
  - uart_data is sampled in the byte_stb cycle.
- FSM advances only on byte_stb, except for timeout and ack:
  - IDLE: 0x55 -> HDR2; any other byte is ignored.
  - HDR2: 0xAA -> CMD; 0x55 -> stay HDR2; other -> IDLE (no error).
  - CMD: latch byte into the cmd register; sum = byte; -> LEN.
  - LEN:
    - byte > MAX_LEN -> IDLE, frm_err with code 2.
    - byte == 0 -> CSUM.
    - otherwise -> DATA, idx = 0.
    - In every case, latch len and sum = sum + byte (mod 256).
  - DATA: buffer[idx] = byte; sum += byte; idx++. Go to CSUM after byte number len.
  - CSUM:
    - byte == sum -> HOLD; frm_valid=1 from the next cycle; frm_cmd/frm_len update together with frm_valid.
    - mismatch -> IDLE, frm_err with code 1; frm_valid stays 0.
  - HOLD:
    - frm_valid=1; frm_cmd, frm_len and buffer are frozen.
    - Each byte_stb without frm_ack: byte dropped, frm_err with code 0.
    - frm_ack -> IDLE; frm_valid=0 next cycle.
- Latency: frm_valid rises 1 cycle after the byte_stb cycle of the CSUM byte.
- Timeout:
  - Counter runs only in HDR2, CMD, LEN, DATA, CSUM; it clears on each byte_stb and on entering IDLE.
  - When the count reaches TIMEOUT_CNT-1 -> IDLE, frm_err with code 3.
  - If byte_stb occurs in the same cycle as the timeout, the byte wins and no timeout is raised.
- Simultaneous frm_ack and byte_stb in HOLD: the ack wins. The byte is evaluated under IDLE rules in that cycle (0x55 -> HDR2) and no overrun is flagged.
- frm_ack outside HOLD is ignored.
- Buffer writes occur only in DATA. A frame that is aborted mid-payload leaves partial buffer contents, but frm_valid is never asserted for it.
- frm_err is high for exactly one cycle per event. err_code updates in the same cycle and holds until the next error.
- Asserting reset mid-frame or in HOLD returns to IDLE immediately and clears outputs. After release, parsing restarts at the next 0x55.

Test Plan:
- Good frame 55 AA 01 02 10 20 33 (uart_done held 200 cycles per byte):
  - frm_valid=1 one cycle after the 7th strobe.
  - frm_cmd=01, frm_len=02; rd_data[0]=10, rd_data[1]=20, rd_data[5]=00.
  - frm_ack -> frm_valid=0 next cycle.
- Bad checksum 55 AA 01 02 10 20 34 -> frm_err pulse, err_code=1, frm_valid stays 0; a following good frame is accepted.
- LEN=0x11 with MAX_LEN=16 -> err_code=2, back to IDLE. Zero-length frame 55 AA 07 00 07 -> frm_valid with frm_len=0.
- TIMEOUT_CNT=100; send 55 AA 01 then idle 100 cycles -> err_code=3.
  - A byte arriving on cycle 99 instead -> no error, parsing continues.
- While in HOLD, send 2 bytes with no ack -> 2 frm_err pulses (code 0), frm_cmd/frm_len/buffer unchanged.
  - Then ack coinciding with a 0x55 strobe -> IDLE then HDR2; the next AA... frame is parsed.
- Assert sys_rst during DATA -> all outputs 0 asynchronously. After release, a full good frame parses correctly.
